// File: rtl/btn_debounce.sv
// Two-channel push-button conditioner: sync, debounce, and press/release/hold events.
// Both channels are identical instances of btn_debounce_ch.
module btn_debounce_ch #(
   parameter int unsigned DEBOUNCE_CYCLES = 270000,
   parameter int unsigned HOLD_CYCLES     = 27000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_n_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic hold_o
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RELEASED,
      S_PRESS_PEND,
      S_PRESSED,
      S_REL_PEND
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    sync_q;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          hit_q, hit_d;
   logic          level_q, press_q, rel_q, hold_q;
   logic          sync;
   logic          acc_lvl;

   assign sync    = sync_q[1];
   assign acc_lvl = (state_q == S_PRESSED) || (state_q == S_REL_PEND);

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      hcnt_d  = hcnt_q;
      hit_d   = 1'b0;
      case (state_q)
         S_RELEASED: begin
            if (sync) begin
               state_d = S_PRESS_PEND;
               cnt_d   = DW'(1);
            end
         end
         S_PRESS_PEND: begin
            if (!sync) begin
               state_d = S_RELEASED;
            end else if (cnt_q == DB_LAST) begin
               state_d = S_PRESSED;
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         S_PRESSED: begin
            if (hcnt_q != HOLD_MAX) begin
               hcnt_d = hcnt_q + HW'(1);
            end
            hit_d = (hcnt_q == HOLD_PRE);
            if (!sync) begin
               state_d = S_REL_PEND;
               cnt_d   = DW'(1);
            end
         end
         S_REL_PEND: begin
            if (sync) begin
               state_d = S_PRESSED;
            end else if (cnt_q == DB_LAST) begin
               state_d = S_RELEASED;
               hcnt_d  = '0;
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         default: begin
            state_d = S_RELEASED;
            hcnt_d  = '0;
         end
      endcase
   end

   // Output stage edge-detects the accepted level so every output is a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= S_RELEASED;
         cnt_q   <= '0;
         hcnt_q  <= '0;
         hit_q   <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], ~pin_n_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hcnt_q  <= hcnt_d;
         hit_q   <= hit_d;
         level_q <= acc_lvl;
         press_q <= acc_lvl & ~level_q;
         rel_q   <= ~acc_lvl & level_q;
         hold_q  <= hit_q;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = rel_q;
   assign hold_o    = hold_q;

endmodule

module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 270000,
   parameter int unsigned HOLD_CYCLES     = 27000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn1,
   input  logic btn2,
   output logic btn1_level,
   output logic btn2_level,
   output logic btn1_press,
   output logic btn2_press,
   output logic btn1_release,
   output logic btn2_release,
   output logic btn1_hold,
   output logic btn2_hold
);

   btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
   ) u_ch1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin_n_i   (btn1),
      .level_o   (btn1_level),
      .press_o   (btn1_press),
      .release_o (btn1_release),
      .hold_o    (btn1_hold)
   );

   btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
   ) u_ch2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin_n_i   (btn2),
      .level_o   (btn2_level),
      .press_o   (btn2_press),
      .release_o (btn2_release),
      .hold_o    (btn2_hold)
   );

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Two-channel push-button conditioner for the board's active-low user buttons. Each raw pin is synchronised, debounced and converted into a clean active-high level plus single-cycle press, release and hold events. The block sits between the button pins and the LED logic, so downstream gate and LED stages only ever see glitch-free signals.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 270000: consecutive stable cycles required to accept a level change (10 ms at 27 MHz); must be ≥ 2.
- HOLD_CYCLES, 27000000: cycles a button must remain accepted-pressed before a hold event (1 s at 27 MHz); must be ≥ 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn1  input  1  raw button 1 pin; low = pressed; asynchronous to clk.
- btn2  input  1  raw button 2 pin; low = pressed; asynchronous to clk.
- btn1_level  output  1  debounced button 1; high = pressed.
- btn2_level  output  1  debounced button 2; high = pressed.
- btn1_press, btn2_press  output  1  one-cycle pulse when a press is accepted.
- btn1_release, btn2_release  output  1  one-cycle pulse when a release is accepted.
- btn1_hold, btn2_hold  output  1  one-cycle pulse after HOLD_CYCLES of continuous accepted press.

## Operation
The two channels are identical and fully independent. The structure below is given per channel.

Synchroniser:
- Two-flop chain on the inverted pin.
- sync = 1 means pressed.
- Both flops reset to 0 (released).

Debounce counter:
- Width is $clog2(DEBOUNCE_CYCLES+1).
- Counts cycles where sync differs from the accepted level.
- Clears to 0 in any cycle where sync equals the accepted level. Any bounce therefore restarts the count.

State machine:
- RELEASED: level = 0. When sync = 1, go to PRESS_PENDING with count = 1.
- PRESS_PENDING: level = 0.
  - If sync = 0, return to RELEASED and clear count.
  - If sync = 1 and count = DEBOUNCE_CYCLES-1, go to PRESSED and assert press for one cycle, coincident with the first cycle of level = 1.
  - Otherwise increment count.
- PRESSED: level = 1.
  - The hold counter (width $clog2(HOLD_CYCLES+1)) increments each cycle. It saturates at HOLD_CYCLES.
  - The hold pulse is asserted exactly once, in the cycle the counter reaches HOLD_CYCLES.
  - When sync = 0, go to RELEASE_PENDING. The hold counter keeps its value.
- RELEASE_PENDING: level = 1; this state mirrors PRESS_PENDING.
  - If sync = 1, return to PRESSED. The hold counter resumes without being cleared, and no hold pulse repeats if it has already fired.
  - On acceptance, go to RELEASED, assert release for one cycle, and clear the hold counter.

Boundary conditions:
- Press and release pulses on the same channel are mutually exclusive.
- Hold never fires in the same cycle as release.
- Simultaneous events on btn1 and btn2 are reported independently in the same cycle.
- Counters never wrap; the debounce count cannot exceed DEBOUNCE_CYCLES-1.

## Timing
Reset values (all outputs and state):
- All outputs 0.
- Both channels in RELEASED.
- All counters 0.
- Synchroniser flops 0.

Reset behaviour:
- Asserting rst_n mid-press or mid-pending forces the reset state immediately, with no pulse.
- After release of reset, a button that is already held produces a normal press after the full latency.

Latency:
- Count edges from the first rising edge at which the pin is stable at its new value.
- The level changes, and the press or release pulse is high, starting at edge 2 + DEBOUNCE_CYCLES.
- The hold pulse follows the press pulse by HOLD_CYCLES cycles.

Interface rules:
- All outputs are registered; none is combinational from the pins.
- Event pulses are exactly one clk wide.
- There is no handshake; consumers sample on every edge.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and HOLD_CYCLES = 10.
- Reset: hold rst_n = 0 with btn1 = btn2 = 1 → all outputs 0. Release reset with no activity for 20 cycles → outputs stay 0.
- Clean press: btn1 driven 0 at edge 0 → btn1_level rises and btn1_press is high for one cycle at edge 6. Hold for 10 more cycles → one btn1_hold pulse at edge 16 and no repeat through edge 40. Drive btn1 to 1 → btn1_release one cycle, 6 edges later.
- Bounce rejection: btn2 toggled 0/1 every 3 cycles for 30 cycles → btn2_level stays 0 and no pulses. Then hold btn2 at 0 → press is accepted 6 edges after the last toggle.
- Release glitch: btn1 pressed and accepted, then a 2-cycle high glitch at hold count 5 → no release pulse, and hold still fires at HOLD_CYCLES total counted press cycles.
- Simultaneous: btn1 and btn2 both driven 0 on the same edge → btn1_press and btn2_press are high in the same cycle. Then release only btn2 → btn1_level remains 1.
- Reset mid-operation: rst_n pulsed low while btn1 is in PRESS_PENDING at count 2 → no press pulse, and level is 0. With btn1 still held low, a press is accepted 6 edges after rst_n deasserts.
